// File: rtl/iq_freelist.sv
// Circular free list of issue-queue slot indices: hands out up to DISP_W slots per
// cycle to dispatch, reclaims up to ISSUE_W slots per cycle from issue.
module iq_freelist #(
    parameter int DEPTH   = 32,
    parameter int INDEX   = 5,
    parameter int DISP_W  = 4,
    parameter int ISSUE_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic [DISP_W-1:0]          alloc_vld_i,
    output logic                       alloc_ready_o,
    output logic [DISP_W*INDEX-1:0]    alloc_idx_o,
    input  logic [ISSUE_W-1:0]         free_vld_i,
    input  logic [ISSUE_W*INDEX-1:0]   free_idx_i,
    output logic [INDEX:0]             free_cnt_o,
    output logic                       err_o
);

    localparam int CW = INDEX + 1;
    localparam int SW = INDEX + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] DISP_C  = CW'(DISP_W);

    logic [INDEX-1:0] fl_r [DEPTH];
    logic [INDEX-1:0] head_r;
    logic [INDEX-1:0] tail_r;
    logic [CW-1:0]    cnt_r;
    logic             err_r;

    logic             alloc_ready_s;
    logic [CW-1:0]    nalloc_s;
    logic [CW-1:0]    nfree_s;
    logic [INDEX-1:0] free_addr_s [ISSUE_W];
    logic [SW-1:0]    sum_s;
    logic             ovf_s;

    // Readiness looks only at registered count so dispatch never sees a comb loop.
    assign alloc_ready_s = (cnt_r >= DISP_C);

    // Valid lanes take consecutive list entries from head, skipping invalid lanes.
    always_comb begin : alloc_lanes
        logic [CW-1:0]    pc;
        logic [INDEX-1:0] addr;
        pc          = '0;
        addr        = '0;
        alloc_idx_o = '0;
        for (int k = 0; k < DISP_W; k++) begin
            addr = head_r + pc[INDEX-1:0];
            alloc_idx_o[k*INDEX +: INDEX] = fl_r[addr];
            if (alloc_vld_i[k]) begin
                pc = pc + CW'(1);
            end else begin
                pc = pc;
            end
        end
        if (alloc_ready_s) begin
            nalloc_s = pc;
        end else begin
            nalloc_s = '0;
        end
    end

    // Released slots are appended at tail in ascending lane order.
    always_comb begin : free_lanes
        logic [CW-1:0] pc;
        pc = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            free_addr_s[j] = tail_r + pc[INDEX-1:0];
            if (free_vld_i[j]) begin
                pc = pc + CW'(1);
            end else begin
                pc = pc;
            end
        end
        nfree_s = pc;
    end

    // One extra bit so an over-release past DEPTH is visible rather than wrapping.
    assign sum_s = SW'(cnt_r) - SW'(nalloc_s) + SW'(nfree_s);
    assign ovf_s = (sum_s > SW'(DEPTH));

    // List, pointers, count and sticky error; flush rebuilds the list but keeps err.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_r[i] <= INDEX'(i);
            end
            head_r <= '0;
            tail_r <= '0;
            cnt_r  <= DEPTH_C;
            err_r  <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_r[i] <= INDEX'(i);
            end
            head_r <= '0;
            tail_r <= '0;
            cnt_r  <= DEPTH_C;
            err_r  <= err_r;
        end else begin
            head_r <= head_r + nalloc_s[INDEX-1:0];
            if (ovf_s) begin
                tail_r <= tail_r;
                cnt_r  <= cnt_r - nalloc_s;
                err_r  <= 1'b1;
            end else begin
                for (int j = 0; j < ISSUE_W; j++) begin
                    if (free_vld_i[j]) begin
                        fl_r[free_addr_s[j]] <= free_idx_i[j*INDEX +: INDEX];
                    end
                end
                tail_r <= tail_r + nfree_s[INDEX-1:0];
                cnt_r  <= sum_s[CW-1:0];
                err_r  <= err_r;
            end
        end
    end

    assign alloc_ready_o = alloc_ready_s;
    assign free_cnt_o    = cnt_r;
    assign err_o         = err_r;

endmodule

// File: doc/iq_freelist.md
Name: iq_freelist

Overview:
- Circular free list of issue-queue slot indices.
- Sits directly upstream of the IQ payload RAM. It hands out up to DISP_W free IQ slot indices per cycle to dispatch, and those indices become the payload/wakeup write addresses.
- Reclaims up to ISSUE_W slot indices per cycle as instructions issue.
- Drives the dispatch stall condition for IQ-full.

Parameters:
- DEPTH, 32, number of IQ entries; must be a power of 2.
- INDEX, 5, log2(DEPTH); width of a slot index.
- DISP_W, 4, dispatch lanes (allocate ports).
- ISSUE_W, 4, issue lanes (free ports).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- flush_i  input  1  IQ flush (recovery): returns every slot to the list.
- alloc_vld_i  input  DISP_W  per-lane allocation request from dispatch.
- alloc_ready_o  output  1  at least DISP_W free entries present.
- alloc_idx_o  output  DISP_W*INDEX  slot index per lane; lane k occupies bits [k*INDEX +: INDEX].
- free_vld_i  input  ISSUE_W  per-lane release valid from issue.
- free_idx_i  input  ISSUE_W*INDEX  released slot index per lane.
- free_cnt_o  output  INDEX+1  current number of free entries.
- err_o  output  1  sticky overflow error.

Behaviour:
- Storage and pointers:
  - fl[DEPTH] of INDEX bits.
  - head_q and tail_q, INDEX bits each, wrap mod DEPTH.
  - cnt_q, INDEX+1 bits.
- Reset (priority over everything):
  - fl[i]=i; head_q=0; tail_q=0; cnt_q=DEPTH; err_o=0.
  - Outputs after reset: free_cnt_o=DEPTH, alloc_ready_o=1, alloc_idx_o lanes = 0..DISP_W-1.
- alloc_ready_o = (cnt_q >= DISP_W). Combinational from registered state only; never depends on alloc_vld_i or free_vld_i.
- alloc_idx_o (combinational):
  - Lane k = fl[head_q + popcount(alloc_vld_i[k-1:0])].
  - Valid lanes receive consecutive list entries in ascending lane order; gaps are skipped.
  - Value on invalid lanes is don't-care.
- Allocate fires when alloc_ready_o=1.
  - nalloc = popcount(alloc_vld_i) if it fires, else 0.
  - Next cycle: head_q += nalloc (mod DEPTH).
  - If alloc_ready_o=0, requests are ignored and state is unchanged; dispatch must stall.
- Free:
  - nfree = popcount(free_vld_i).
  - Valid lane j writes fl[tail_q + popcount(free_vld_i[j-1:0])] = its free_idx_i field.
  - tail_q += nfree.
- Count:
  - cnt_q_next = cnt_q - nalloc + nfree.
  - Freed indices are not allocatable in the same cycle (zero bypass); they become visible the cycle after.
- Overflow:
  - Condition: cnt_q - nalloc + nfree > DEPTH.
  - On overflow, the free half of the update is suppressed (no fl write, no tail/cnt contribution); allocation still applies.
  - err_o set to 1 the next cycle and held until reset.
- flush_i:
  - Synchronous; priority over alloc/free in the same cycle.
  - Next state equals reset state, except err_o, which is retained.
- Wrap-around:
  - Head and tail crossing DEPTH-1 wrap to 0, including mid-group (lane 0 at slot 31, lane 1 at slot 0).
- Full/empty:
  - head_q==tail_q is ambiguous; cnt_q is the sole arbiter of full vs empty.
- No duplicate-index checking on free; correctness of released indices is the issue stage's responsibility.

Test Plan:
- Reset, then idle one cycle -> free_cnt_o=32, alloc_ready_o=1, alloc_idx lanes = 0,1,2,3, err_o=0.
- alloc_vld_i=4'b1011 -> lanes 0/1/3 get 0/1/2 that cycle. Next cycle free_cnt_o=29, lane0 idx=3.
- Allocate 4'b1111 for 8 consecutive cycles -> free_cnt_o steps 28..0; alloc_ready_o=0 after the 8th. A 9th alloc_vld_i=4'b1111 leaves cnt=0 and head=0.
- From empty (head=tail=0):
  - Free vld=4'b0101 with idx lane0=7, lane2=20 -> cnt=2, ready=0.
  - Then free lane0=9, lane1=11 -> cnt=4, ready=1, alloc_idx lanes = 7,20,9,11.
- At cnt=4, same cycle alloc 4'b1111 + free 2 entries (idx 5, 6) -> lanes get the old four entries, not 5/6. Next cycle cnt=2 and lane0 idx=5.
- Overflow then flush:
  - From reset, free_vld_i=4'b0001 -> next cycle err_o=1, cnt stays 32.
  - Allocate 8, then assert flush_i with alloc_vld_i=4'b1111 and free_vld_i=4'b1111 -> next cycle cnt=32, lanes = 0,1,2,3, err_o still 1.
  - Then reset -> err_o=0.
